ringosc_meas_ctrl: RTL and testbench

//   Sequencer for the ring-oscillator frequency-measurement datapath. Drives the oscillator

---
 rtl/ringosc_meas_ctrl_pkg.sv | 10 +
 rtl/ringosc_meas_ctrl_phase_timer.sv | 16 +
 rtl/ringosc_meas_ctrl.sv | 76 +++++++
 tb/tb_ringosc_meas_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/ringosc_meas_ctrl_pkg.sv
// ringosc_meas_ctrl_pkg: shared state encoding for the ring-oscillator measurement sequencer
package ringosc_meas_ctrl_pkg;
  typedef enum logic [2:0] {
    OFF   = 3'd0,
    CLEAR = 3'd1,
    COUNT = 3'd2,
    HOLD  = 3'd3,
    EVAL  = 3'd4
  } state_t;
endpackage

// File: rtl/ringosc_meas_ctrl_phase_timer.sv
// ringosc_meas_ctrl_phase_timer: counts 0..LEN-1, strobes done on the last cycle and wraps
module ringosc_meas_ctrl_phase_timer #(
  parameter int LEN = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);
  localparam int W = $clog2(LEN);
  logic [W-1:0] cnt;
  assign done = cnt == W'(LEN - 1);
  always_ff @(posedge clk) begin
    cnt <= (rst || clr || done) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/ringosc_meas_ctrl.sv
// ringosc_meas_ctrl: phases the oscillator counter, captures counts and flags debounced frequency drops
module ringosc_meas_ctrl
  import ringosc_meas_ctrl_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int PHASE_LEN  = 65536,
  parameter int THRESH     = 5,
  parameter int DEBOUNCE_N = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [CNT_W-1:0] CNT_VAL,
  output logic             OSC_EN,
  output logic             CNT_CLR,
  output logic             CNT_EN,
  output logic [CNT_W-1:0] SAMPLE,
  output logic             SAMPLE_VALID,
  output logic             STALL,
  output logic             DROP_EVT,
  output logic             DETECT
);
  localparam int DW = $clog2(DEBOUNCE_N + 1);
  state_t state, state_n;
  logic done, hit, cur_nz;
  logic [CNT_W-1:0] prev;
  logic prev_valid;
  logic [DW-1:0] db, db_n;
  ringosc_meas_ctrl_phase_timer #(.LEN(PHASE_LEN)) u_timer (
    .clk (CLK),
    .rst (RST),
    .clr ((state_n != state) || (state == OFF)),
    .done(done)
  );
  assign OSC_EN  = state != OFF;
  assign CNT_CLR = state == CLEAR;
  assign CNT_EN  = state == COUNT;
  always_comb begin
    state_n = !EN ? OFF :
              (state == OFF || state == EVAL) ? CLEAR :
              !done ? state :
              state == CLEAR ? COUNT :
              state == COUNT ? HOLD : EVAL;
    cur_nz  = CNT_VAL != '0;
    // one extra bit keeps cur+THRESH from wrapping near full scale
    hit     = state == EVAL && cur_nz && prev_valid &&
              {1'b0, prev} > ({1'b0, CNT_VAL} + (CNT_W + 1)'(THRESH));
    db_n    = state != EVAL ? db :
              hit ? DW'(DEBOUNCE_N) : db - DW'(db != '0);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= OFF;
      SAMPLE       <= '0;
      SAMPLE_VALID <= 1'b0;
      STALL        <= 1'b0;
      DROP_EVT     <= 1'b0;
      DETECT       <= 1'b0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      db           <= '0;
    end else begin
      state        <= state_n;
      db           <= db_n;
      DETECT       <= db_n != '0;
      DROP_EVT     <= hit && db == '0;
      SAMPLE_VALID <= state == EVAL && cur_nz;
      STALL        <= state == EVAL && !cur_nz;
      if (state == EVAL && cur_nz) begin
        SAMPLE <= CNT_VAL;
        prev   <= CNT_VAL;
      end
      prev_valid <= !EN ? 1'b0 : state == EVAL ? cur_nz : prev_valid;
    end
  end
endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// tb_ringosc_meas_ctrl: directed checks of phasing, capture, drop detection and debounce
module tb_ringosc_meas_ctrl;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [19:0] cnt_val = '0;
  logic osc_en, cnt_clr, cnt_en, sample_valid, stall, drop_evt, detect;
  logic [19:0] sample;
  int total = 0, bad = 0;
  logic r_valid, r_stall, r_drop, r_det;
  logic [19:0] r_sample;

  ringosc_meas_ctrl #(.CNT_W(20), .PHASE_LEN(8), .THRESH(5), .DEBOUNCE_N(7)) dut (
    .CLK(clk), .RST(rst), .EN(en), .CNT_VAL(cnt_val),
    .OSC_EN(osc_en), .CNT_CLR(cnt_clr), .CNT_EN(cnt_en), .SAMPLE(sample),
    .SAMPLE_VALID(sample_valid), .STALL(stall), .DROP_EVT(drop_evt), .DETECT(detect)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic round(input logic [19:0] v);
    bit found = 0;
    cnt_val = v;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = sample_valid || stall;
    end
    if (!found) check("round_timeout", 0, 1);
    r_valid = sample_valid; r_stall = stall; r_drop = drop_evt; r_det = detect; r_sample = sample;
  endtask

  task automatic wait_hold();
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = osc_en && !cnt_clr && !cnt_en;
    end
    if (!found) check("hold_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outs", {osc_en, cnt_clr, cnt_en, sample_valid, stall, drop_evt, detect}, 0);
    check("rst_sample", sample, 0);
    rst = 1'b0;
    cnt_val = 20'd1000;
    @(negedge clk);
    check("off_osc", osc_en, 0);
    en = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 1 || k == 8) check("t1_clr", cnt_clr, 1);
      if (k == 9) check("t1_clr_end", {cnt_clr, cnt_en}, 2'b01);
      if (k == 16) check("t1_en", cnt_en, 1);
      if (k == 17) check("t1_hold", {osc_en, cnt_clr, cnt_en}, 3'b100);
      if (k == 25) check("t1_early", sample_valid, 0);
      if (k == 26) begin
        check("t1_valid", sample_valid, 1);
        check("t1_sample", sample, 1000);
        check("t1_drop", drop_evt, 0);
      end
    end
    round(20'd995);  check("t2_995", {r_valid, r_drop}, 2'b10);
    round(20'd994);  check("t2_994", {r_drop, r_sample}, {1'b0, 20'd994});
    round(20'd1000); check("t2_rise", r_drop, 0);
    round(20'd994);  check("t2_drop", {r_drop, r_det}, 2'b11);
    for (int i = 1; i <= 3; i++) begin
      round(20'd994); check("t3_flat_a", {r_drop, r_det}, 2'b01);
    end
    round(20'd988); check("t3_redrop", {r_drop, r_det}, 2'b01);
    for (int i = 1; i <= 7; i++) begin
      round(20'd988); check("t3_window", r_det, i < 7);
    end
    round(20'd982); check("t3_new_drop", {r_drop, r_det}, 2'b11);
    round(20'd0);   check("t4_stall", {r_stall, r_valid}, 2'b10);
    check("t4_keep", r_sample, 982);
    round(20'd900); check("t4_nocmp", {r_valid, r_drop}, 2'b10);
    check("t4_sample", r_sample, 900);
    round(20'd900);
    for (int i = 0; i < 40 && !cnt_en; i++) @(negedge clk);
    check("t5_in_count", cnt_en, 1);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("t5_off", {osc_en, cnt_clr, cnt_en}, 0);
    check("t5_det_hold", detect, 1);
    repeat (5) @(negedge clk);
    check("t5_stay_off", osc_en, 0);
    en = 1'b1;
    round(20'd800); check("t5_restart", {r_valid, r_drop}, 2'b10);
    round(20'd794); check("t5_hit_busy", {r_drop, r_det}, 2'b01);
    wait_hold();
    check("t6_det", detect, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_outs", {osc_en, cnt_clr, cnt_en, sample_valid, stall, drop_evt, detect}, 0);
    check("t6_sample", sample, 0);
    rst = 1'b0;
    round(20'hFFFFA); check("t7_first", {r_valid, r_drop}, 2'b10);
    round(20'hFFFFF); check("t7_nowrap", r_drop, 0);
    round(20'hFFFF9); check("t7_hit", {r_drop, r_det}, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
